// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types and sizing for the retire-side recovery sequencer.
// Retire width and recovery timing defaults sit beside the ROB sizing constants.
package rob_recovery_ctrl_pkg;

    localparam int ROB_RETIRE_W          = 3;
    localparam int XLEN_DEFAULT          = 32;
    localparam int SETTLE_CYCLES_DEFAULT = 2;
    localparam int DRAIN_MAX_DEFAULT     = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_REDIRECT = 3'd4,
        ST_HALTED   = 3'd5
    } rec_state_e;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_RECOVER = 2'd1,
        EVT_HALT    = 2'd2
    } evt_kind_e;

    typedef struct packed {
        logic                    valid;
        logic                    recover;
        logic                    halt;
        logic [XLEN_DEFAULT-1:0] target;
    } retire_evt_t;

endpackage

// File: rtl/rob_recovery_ctrl_if.sv
// Retire group, store-queue, fetch redirect and status bundle for rob_recovery_ctrl.
interface rob_recovery_ctrl_if
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic [ROB_RETIRE_W-1:0]           ret_valid;
    logic [ROB_RETIRE_W-1:0]           ret_recover;
    logic [ROB_RETIRE_W-1:0][XLEN-1:0] ret_target;
    logic [ROB_RETIRE_W-1:0]           ret_halt;
    logic                              sq_empty;
    logic                              fetch_ack;
    logic [ROB_RETIRE_W-1:0]           retire_mask;
    logic                              rec_enable;
    logic                              redirect_valid;
    logic [XLEN-1:0]                   redirect_pc;
    logic                              dispatch_stall;
    logic                              halted;
    logic [31:0]                       perf_recoveries;
    logic [31:0]                       perf_stall_cycles;

    modport master (
        output ret_valid, ret_recover, ret_target, ret_halt, sq_empty, fetch_ack,
        input  retire_mask, rec_enable, redirect_valid, redirect_pc, dispatch_stall,
               halted, perf_recoveries, perf_stall_cycles
    );

    modport slave (
        input  ret_valid, ret_recover, ret_target, ret_halt, sq_empty, fetch_ack,
        output retire_mask, rec_enable, redirect_valid, redirect_pc, dispatch_stall,
               halted, perf_recoveries, perf_stall_cycles
    );
endinterface

// File: rtl/rob_recovery_ctrl_retire_event_pick.sv
// Oldest-first event picker over the retire group (slot 2 oldest).
// Halt outranks recover when both sit in the same slot.
module retire_event_pick
    import rob_recovery_ctrl_pkg::*;
(
    input  retire_evt_t [ROB_RETIRE_W-1:0] evt,
    output logic [ROB_RETIRE_W-1:0]        mask,
    output evt_kind_e                      win_kind,
    output logic [XLEN_DEFAULT-1:0]        win_target
);
    logic       found;
    logic [1:0] win_idx;

    always_comb begin
        mask     = '0;
        win_kind = EVT_NONE;
        win_idx  = '0;
        found    = 1'b0;
        for (int i = ROB_RETIRE_W - 1; i >= 0; i--) begin
            if (!found && evt[i].valid) begin
                mask[i] = 1'b1;
                if (evt[i].halt) begin
                    found    = 1'b1;
                    win_kind = EVT_HALT;
                    win_idx  = 2'(i);
                end else if (evt[i].recover) begin
                    found    = 1'b1;
                    win_kind = EVT_RECOVER;
                    win_idx  = 2'(i);
                end
            end
        end
    end

    assign win_target = evt[win_idx].target;

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Retire-side commit gating and mispredict recovery sequencer (flush, settle, drain, redirect).
// Optional perf counters are built only when RECOVERY_PERF_EN is defined.
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int XLEN          = XLEN_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int DRAIN_MAX     = DRAIN_MAX_DEFAULT
) (
    input logic clk,
    input logic rst,
    rob_recovery_ctrl_if.slave bus
);
    localparam int DRAIN_W = $clog2(DRAIN_MAX);

    retire_evt_t [ROB_RETIRE_W-1:0] evt;
    logic [ROB_RETIRE_W-1:0]        pick_mask;
    evt_kind_e                      win_kind;
    logic [XLEN_DEFAULT-1:0]        win_target;

    rec_state_e          state_q, state_d;
    logic [3:0]          settle_q, settle_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [XLEN-1:0]     redirect_pc_q;
    logic                start_rec;

    logic [ROB_RETIRE_W-1:0] retire_mask;
    logic                    rec_enable, redirect_valid, dispatch_stall, halted;

    always_comb begin
        for (int i = 0; i < ROB_RETIRE_W; i++) begin
            evt[i].valid   = bus.ret_valid[i];
            evt[i].recover = bus.ret_recover[i];
            evt[i].halt    = bus.ret_halt[i];
            evt[i].target  = bus.ret_target[i];
        end
    end

    retire_event_pick u_pick (
        .evt        (evt),
        .mask       (pick_mask),
        .win_kind   (win_kind),
        .win_target (win_target)
    );

    // Retire inputs only matter in IDLE, which is what rules out nested recovery.
    assign start_rec = (state_q == ST_IDLE) && (win_kind == EVT_RECOVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            drain_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            drain_q  <= drain_d;
            if (start_rec)
                redirect_pc_q <= win_target;
        end
    end

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        drain_d        = drain_q;
        retire_mask    = '0;
        rec_enable     = 1'b0;
        redirect_valid = 1'b0;
        dispatch_stall = 1'b0;
        halted         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                retire_mask = pick_mask;
                if (win_kind == EVT_HALT)
                    state_d = ST_HALTED;
                else if (win_kind == EVT_RECOVER)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                rec_enable     = 1'b1;
                dispatch_stall = 1'b1;
                settle_d       = 4'(SETTLE_CYCLES - 1);
                state_d        = ST_SETTLE;
            end
            ST_SETTLE: begin
                dispatch_stall = 1'b1;
                if (settle_q == '0) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                dispatch_stall = 1'b1;
                // A stuck store queue must not wedge the front end forever.
                if (bus.sq_empty || drain_q == DRAIN_W'(DRAIN_MAX - 1))
                    state_d = ST_REDIRECT;
                else
                    drain_d = drain_q + 1'b1;
            end
            ST_REDIRECT: begin
                dispatch_stall = 1'b1;
                redirect_valid = 1'b1;
                if (bus.fetch_ack)
                    state_d = ST_IDLE;
            end
            ST_HALTED: begin
                dispatch_stall = 1'b1;
                halted         = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.retire_mask    = retire_mask;
    assign bus.rec_enable     = rec_enable;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.dispatch_stall = dispatch_stall;
    assign bus.halted         = halted;

`ifdef RECOVERY_PERF_EN
    logic [31:0] perf_rec_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rec_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (start_rec)
                perf_rec_q <= perf_rec_q + 32'd1;
            if (dispatch_stall)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign bus.perf_recoveries   = perf_rec_q;
    assign bus.perf_stall_cycles = perf_stall_q;
`else
    assign bus.perf_recoveries   = '0;
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Scoreboard bench for rob_recovery_ctrl: driver predicts per-episode outcomes, monitor compares.
module tb_rob_recovery_ctrl;
    localparam int XLEN = 32;
    localparam int S    = 2;
    localparam int DMAX = 64;

    typedef struct {
        logic [XLEN-1:0] target;
        int              lat;
        int              stall_len;
        int              ack;
    } ep_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_recovery_ctrl_if #(.XLEN(XLEN)) bus ();

    rob_recovery_ctrl #(
        .XLEN          (XLEN),
        .SETTLE_CYCLES (S),
        .DRAIN_MAX     (DMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ep_t         ep_q[$];
    logic [2:0]  mask_q[$];
    int          halt_q[$];
    int          vectors = 0;
    int          fails   = 0;
    int          n_rec   = 0;
    logic [31:0] stall_sum = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks every observed output and plays the fetch side of the redirect handshake.
    initial begin : monitor
        ep_t cur;
        bit  in_ep, acked, rv_seen, halt_mode, post_rst, prev_rec;
        int  cyc, stall_n, waitc;
        in_ep = 0; acked = 0; rv_seen = 0; halt_mode = 0; post_rst = 0; prev_rec = 0;
        cyc = 0; stall_n = 0; waitc = 0;
        bus.fetch_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ep_q.delete(); mask_q.delete(); halt_q.delete();
                in_ep = 0; acked = 0; halt_mode = 0; prev_rec = 0; post_rst = 1;
                bus.fetch_ack = 1'b0;
                continue;
            end
            if (post_rst) begin
                chk("reset_flags", {bus.retire_mask, bus.rec_enable, bus.redirect_valid,
                                    bus.dispatch_stall, bus.halted}, 0);
                chk("reset_redirect_pc", bus.redirect_pc, 0);
                chk("reset_perf", {bus.perf_recoveries, bus.perf_stall_cycles}, 0);
                post_rst = 0;
            end
            if (bus.ret_valid != 3'b000) begin
                chk("mask_q_size", mask_q.size() > 0, 1);
                if (mask_q.size() > 0) chk("retire_mask", bus.retire_mask, mask_q.pop_front());
            end
            if (bus.halted && !halt_mode) begin
                chk("halt_expected", halt_q.size(), 1);
                if (halt_q.size() > 0) void'(halt_q.pop_front());
                halt_mode = 1;
            end
            if (halt_mode)
                chk("halted_outputs", {bus.halted, bus.dispatch_stall, bus.rec_enable,
                                       bus.redirect_valid}, 4'b1100);
            if (bus.rec_enable) begin
                chk("rec_enable_pulse", prev_rec, 0);
                chk("flush_expected", (ep_q.size() > 0) && !in_ep, 1);
                if (ep_q.size() > 0 && !in_ep) begin
                    cur = ep_q.pop_front();
                    in_ep = 1; acked = 0; rv_seen = 0; cyc = 0; stall_n = 0; waitc = 0;
                end
            end
            prev_rec = bus.rec_enable;
            if (in_ep) begin
                if (acked) begin
                    chk("stall_drop", {bus.dispatch_stall, bus.redirect_valid}, 0);
                    chk("stall_len", stall_n, cur.stall_len);
                    in_ep = 0; acked = 0;
                    bus.fetch_ack = 1'b0;
                end else begin
                    if (bus.dispatch_stall) stall_n++;
                    if (bus.redirect_valid) begin
                        if (!rv_seen) chk("redirect_lat", cyc, cur.lat);
                        rv_seen = 1;
                        chk("redirect_pc", bus.redirect_pc, cur.target);
                        if (waitc == cur.ack) begin
                            bus.fetch_ack = 1'b1;
                            acked = 1;
                        end else begin
                            bus.fetch_ack = 1'b0;
                        end
                        waitc++;
                    end
                    cyc++;
                    if (cyc > 300) begin
                        chk("episode_timeout", cyc, cur.stall_len);
                        in_ep = 0;
                        bus.fetch_ack = 1'b0;
                    end
                end
            end else if (!halt_mode) begin
                chk("idle_outputs", {bus.dispatch_stall, bus.redirect_valid, bus.halted,
                                     bus.rec_enable}, 0);
            end
        end
    end

    task automatic garbage_cycle();
        @(posedge clk); #1;
        bus.ret_valid   = 3'($urandom_range(0, 7));
        bus.ret_recover = 3'($urandom_range(0, 7));
        bus.ret_halt    = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) bus.ret_target[i] = $urandom;
        if (bus.ret_valid != 3'b000) mask_q.push_back(3'b000);
    endtask

    // One retire group presented in IDLE. sq_empty rises e_rel cycles later; ack after a redirect cycles.
    task automatic idle_step(input logic [2:0] v, input logic [2:0] r, input logic [2:0] h,
                             input logic [2:0][XLEN-1:0] t, input int e_rel, input int a);
        logic [2:0] ev, low, exp;
        int e, d, stall;
        @(posedge clk); #1;
        bus.ret_valid = v; bus.ret_recover = r; bus.ret_halt = h; bus.ret_target = t;
        bus.sq_empty = (e_rel <= 0);
        ev = v & (r | h);
        e = -1;
        for (int i = 0; i < 3; i++) if (ev[i]) e = i;
        if (e < 0) exp = v;
        else begin
            low = (3'd1 << e) - 3'd1;
            exp = v & ~low;
        end
        if (v != 3'b000) mask_q.push_back(exp);
        if (e >= 0 && h[e]) begin
            halt_q.push_back(1);
        end else if (e >= 0) begin
            d = (e_rel <= S + 2) ? 1 : e_rel - (S + 2) + 1;
            if (d > DMAX) d = DMAX;
            stall = S + d + a + 2;
            ep_q.push_back('{t[e], S + 1 + d, stall, a});
            n_rec++;
            stall_sum += 32'(stall);
            for (int k = 1; k <= stall; k++) begin
                garbage_cycle();
                bus.sq_empty = (k >= e_rel);
            end
        end
    endtask

    task automatic check_perf();
        @(posedge clk); #1;
        bus.ret_valid = '0; bus.ret_recover = '0; bus.ret_halt = '0;
`ifdef RECOVERY_PERF_EN
        chk("perf_recoveries", bus.perf_recoveries, n_rec);
        chk("perf_stall_cycles", bus.perf_stall_cycles, stall_sum);
`else
        chk("perf_recoveries", bus.perf_recoveries, 0);
        chk("perf_stall_cycles", bus.perf_stall_cycles, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.ret_valid = '0; bus.ret_recover = '0; bus.ret_halt = '0; bus.sq_empty = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_rec = 0;
        stall_sum = '0;
    endtask

    initial begin : driver
        logic [2:0][XLEN-1:0] t;
        rst = 1'b1;
        bus.ret_valid = '0; bus.ret_recover = '0; bus.ret_halt = '0;
        bus.ret_target = '0; bus.sq_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        t = '0;
        for (int n = 0; n < 10; n++) idle_step(3'b111, 3'b000, 3'b000, t, 1, 0);

        t[1] = 32'h400;
        idle_step(3'b111, 3'b010, 3'b000, t, 1, 0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 3; i++) t[i] = $urandom;
            idle_step(3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      3'b000, t, $urandom_range(1, S + 8), $urandom_range(0, 3));
        end

        t[1] = 32'hdead_beef;
        idle_step(3'b010, 3'b010, 3'b000, t, 100000, 10);

        for (int n = 0; n < 3; n++) begin
            t[2] = 32'h1000 + 32'(n);
            idle_step(3'b100, 3'b100, 3'b000, t, 1, n);
        end
        check_perf();

        // Reset lands in the second DRAIN cycle of a stalled drain.
        @(posedge clk); #1;
        t[0] = 32'h2222_0000;
        bus.ret_valid = 3'b001; bus.ret_recover = 3'b001; bus.ret_halt = 3'b000;
        bus.ret_target = t; bus.sq_empty = 1'b0;
        mask_q.push_back(3'b001);
        ep_q.push_back('{t[0], 0, 0, 0});
        for (int k = 1; k <= S + 3; k++) begin
            @(posedge clk); #1;
            bus.ret_valid = '0; bus.ret_recover = '0;
            if (k == S + 3) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_rec = 0;
        stall_sum = '0;
        t[2] = 32'h3333_0000;
        idle_step(3'b111, 3'b100, 3'b000, t, 2, 1);
        check_perf();

        t[0] = 32'h4444_0000;
        idle_step(3'b111, 3'b001, 3'b100, t, 1, 0);
        for (int n = 0; n < 6; n++) garbage_cycle();
        do_reset();
        idle_step(3'b011, 3'b000, 3'b000, t, 1, 0);

        @(negedge clk); #1;
        chk("ep_q_left", ep_q.size(), 0);
        chk("mask_q_left", mask_q.size(), 0);
        chk("halt_q_left", halt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/rob_recovery_ctrl.md
Name: rob_recovery_ctrl

Overview:
Retire-side sequencer placed after the 3-wide reorder buffer.
- Each cycle it inspects the up-to-3 retiring entries and decides which of them architecturally commit.
- On a mispredicted branch (precise_state_need) it runs a multi-cycle recovery: flush pulse, settle, store-queue drain, then a fetch redirect handshake.
- A retiring halt is also detected and parks the machine.
- It is the single source of the flush-enable that resets ROB, RS, LSQ and map tables.

Parameters:
XLEN, 32, PC width
SETTLE_CYCLES, 2, cycles dispatch stays stalled after the flush pulse before drain checking starts (legal 1..15)
DRAIN_MAX, 64, maximum cycles spent in DRAIN before forcing the redirect

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ret_valid  in  3  retiring slot valid; slot 2 oldest, slot 0 youngest
ret_recover  in  3  slot's precise_state_need
ret_target  in  3xXLEN  slot's recovery PC
ret_halt  in  3  slot is a halt instruction
sq_empty  in  1  store queue holds no retired-uncommitted stores
fetch_ack  in  1  fetch accepted redirect
retire_mask  out  3  slots allowed to commit architecturally
rec_enable  out  1  one-cycle global flush pulse
redirect_valid  out  1  redirect request
redirect_pc  out  XLEN  redirect target
dispatch_stall  out  1  block dispatch
halted  out  1  machine halted
perf_recoveries  out  32  recovery count
perf_stall_cycles  out  32  cycles with dispatch_stall=1

Behaviour:
- States: IDLE, FLUSH, SETTLE, DRAIN, REDIRECT, HALTED.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Counters are 0.
  - redirect_pc is 0.
- retire_mask in IDLE is combinational.
  - Scan slots 2→0 over valid slots and stop at the first slot with ret_recover or ret_halt.
  - That stopping slot and all older valid slots are set in the mask; younger slots are cleared.
  - With no event, mask = ret_valid.
  - retire_mask = 0 in every other state.
- Simultaneous events: the oldest event wins.
  - Recover and halt in the same slot: halt wins; no redirect is issued.
- IDLE → FLUSH on a winning recover.
  - Register the winner's ret_target into redirect_pc on that edge.
- IDLE → HALTED on a winning halt.
- FLUSH (exactly 1 cycle):
  - rec_enable=1 and dispatch_stall=1.
  - Load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - dispatch_stall=1.
  - Decrement the counter; at 0 go to DRAIN and clear the drain counter.
- DRAIN:
  - dispatch_stall=1.
  - If sq_empty, go to REDIRECT.
  - Otherwise increment the drain counter; at DRAIN_MAX-1 go to REDIRECT anyway (timeout).
- REDIRECT:
  - dispatch_stall=1 and redirect_valid=1; redirect_pc is held stable.
  - On fetch_ack go to IDLE. dispatch_stall drops the following cycle.
  - redirect_valid and redirect_pc must not change until acked.
- HALTED:
  - halted=1 and dispatch_stall=1.
  - ret_* inputs are ignored; only rst exits this state.
- ret_* inputs are ignored outside IDLE, so no nested recovery is possible.
- rst mid-recovery returns to IDLE next edge; no further rec_enable pulse is issued.
- rec_enable is never high for two consecutive cycles.

Optional Feature:
- Macro: RECOVERY_PERF_EN.
- When defined:
  - perf_recoveries increments on each IDLE→FLUSH transition.
  - perf_stall_cycles increments each cycle dispatch_stall=1.
  - Both counters wrap at 2^32 and are cleared by rst.
- When undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared package: the recovery state enum (3-bit), and a retire-event packet typedef {valid, recover, halt, target}.
- Constants SETTLE_CYCLES_DEFAULT and DRAIN_MAX_DEFAULT live beside the ROB size constants.
- One sub-module: retire_event_pick.
  - Purely combinational oldest-event priority picker.
  - Produces the mask, winner index, winner kind, and winner target.
- The FSM, counters and perf logic stay in the top module.

Test Plan:
1. ret_valid=111, no events → retire_mask=111 every cycle, dispatch_stall=0, rec_enable never asserted.
2. ret_valid=111, ret_recover=010, target slot1=0x400, sq_empty=1, fetch_ack=1 on its first request cycle:
   - Same cycle: retire_mask=110.
   - Next cycle: rec_enable=1.
   - Then 2 SETTLE cycles, DRAIN 1 cycle, REDIRECT with redirect_pc=0x400 for 1 cycle, then IDLE.
   - dispatch_stall=1 for exactly 5 cycles.
3. ret_recover=001 and ret_halt=100 in the same group → retire_mask=100, then HALTED; halted=1, no rec_enable, no redirect.
4. Recovery with sq_empty=0 held → redirect_valid asserted after exactly DRAIN_MAX=64 DRAIN cycles; with fetch_ack held low, redirect_pc is stable for 10 cycles.
5. rst asserted in the second DRAIN cycle → next cycle all outputs are 0, state is IDLE, and a fresh recover is accepted normally.
6. With RECOVERY_PERF_EN, three back-to-back recoveries → perf_recoveries=3 and perf_stall_cycles equals the summed stall cycles; without the macro both read 0.
